// File: rtl/tlu_trigger_emulator.sv
// tlu_trigger_emulator
// Emulates the TLU side of the trigger/busy/clock handshake: issues triggers
// on request (or from an optional rate generator), waits for the DUT BUSY and
// returns the trigger number serially on TLU_TRIGGER, clocked by TLU_CLOCK.
// Optional feature macro: TLU_EMULATOR_RATE_GEN_EN builds the periodic
// trigger generator; without it TRIGGER_PERIOD is accepted but ignored.
module tlu_trigger_emulator #(
    parameter int NUMBER_WIDTH = 15,
    parameter int PULSE_CYCLES = 4,
    parameter int DEAD_CYCLES  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_enable,
    input  logic [1:0]              i_tlu_mode,
    input  logic                    i_trigger_req,
    input  logic [15:0]             i_trigger_period,
    input  logic [7:0]              i_handshake_timeout,
    input  logic                    i_error_clear,
    input  logic                    i_tlu_busy,
    input  logic                    i_tlu_clock,
    input  logic                    i_tlu_assert_veto,
    output logic                    o_tlu_trigger,
    output logic [NUMBER_WIDTH-1:0] o_trigger_number,
    output logic                    o_timeout_error,
    output logic [15:0]             o_skipped_count,
    output logic                    o_idle_flag
);

    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_TRIG_HIGH     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY_LOW = 3'd2;
    localparam logic [2:0] S_SHIFT         = 3'd3;
    localparam logic [2:0] S_DEAD          = 3'd4;

    logic [2:0]              r_state;
    logic [1:0]              r_mode;
    logic [15:0]             r_cnt;
    logic [31:0]             r_shift;
    logic [NUMBER_WIDTH-1:0] r_number;
    logic                    r_trigger;
    logic                    r_timeout_error;
    logic [15:0]             r_skipped;

    logic r_busy_meta, r_busy_sync;
    logic r_tclk_meta, r_tclk_sync, r_tclk_prev;
    logic r_veto_meta, r_veto_sync;

    logic w_tick;
    logic w_req;
    logic w_accept;
    logic w_tclk_rise;
    logic w_timeout;

    // Two-flop synchronizers for the DUT-side asynchronous inputs, plus one
    // extra stage on TLU_CLOCK for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy_meta <= 1'b0;
            r_busy_sync <= 1'b0;
            r_tclk_meta <= 1'b0;
            r_tclk_sync <= 1'b0;
            r_tclk_prev <= 1'b0;
            r_veto_meta <= 1'b0;
            r_veto_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage samples the previous stage's old value.
            r_busy_meta <= i_tlu_busy;
            r_busy_sync <= r_busy_meta;
            r_tclk_meta <= i_tlu_clock;
            r_tclk_sync <= r_tclk_meta;
            r_tclk_prev <= r_tclk_sync;
            r_veto_meta <= i_tlu_assert_veto;
            r_veto_sync <= r_veto_meta;
        end
    end

`ifdef TLU_EMULATOR_RATE_GEN_EN
    logic [15:0] r_rate_cnt;

    assign w_tick = (i_trigger_period != 16'd0) &&
                    (r_rate_cnt >= i_trigger_period - 16'd1);

    // Free-running period counter; a zero period stops and clears it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rate_cnt <= 16'd0;
        end else if (i_trigger_period == 16'd0 || w_tick) begin
            r_rate_cnt <= 16'd0;
        end else begin
            r_rate_cnt <= r_rate_cnt + 16'd1;
        end
    end
`else
    logic w_unused_period;

    assign w_unused_period = ^i_trigger_period;
    assign w_tick          = 1'b0;
`endif

    // A tick and a request in the same cycle merge into one request.
    assign w_req       = i_trigger_req | w_tick;
    assign w_accept    = w_req && (r_state == S_IDLE) && i_enable && !r_veto_sync;
    assign w_tclk_rise = r_tclk_sync & ~r_tclk_prev;
    assign w_timeout   = (r_state == S_TRIG_HIGH) && r_mode[1] && !r_busy_sync &&
                         (i_handshake_timeout != 8'd0) &&
                         (r_cnt == 16'(i_handshake_timeout) - 16'd1);

    // Sticky timeout flag and saturating skip counter; clear wins over events.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_timeout_error <= 1'b0;
            r_skipped       <= 16'd0;
        end else if (i_error_clear) begin
            r_timeout_error <= 1'b0;
            r_skipped       <= 16'd0;
        end else begin
            if (w_timeout) begin
                r_timeout_error <= 1'b1;
            end
            if (w_req && !w_accept && r_skipped != 16'hFFFF) begin
                r_skipped <= r_skipped + 16'd1;
            end
        end
    end

    // Handshake state machine; the trigger line is registered alongside it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'b00;
            r_cnt     <= 16'd0;
            r_shift   <= 32'd0;
            r_number  <= '0;
            r_trigger <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_trigger <= 1'b0;
                    if (w_accept) begin
                        r_state   <= S_TRIG_HIGH;
                        r_trigger <= 1'b1;
                        r_mode    <= i_tlu_mode;
                        r_cnt     <= 16'd0;
                        r_shift   <= 32'(r_number);
                        r_number  <= r_number + NUMBER_WIDTH'(1);
                    end
                end
                S_TRIG_HIGH: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (!r_mode[1]) begin
                        if (r_cnt == 16'(PULSE_CYCLES - 1)) begin
                            r_state   <= S_DEAD;
                            r_trigger <= 1'b0;
                            r_cnt     <= 16'd0;
                        end
                    end else if (r_busy_sync) begin
                        r_trigger <= 1'b0;
                        r_state   <= r_mode[0] ? S_SHIFT : S_WAIT_BUSY_LOW;
                    end else if (w_timeout) begin
                        r_state   <= S_DEAD;
                        r_trigger <= 1'b0;
                        r_cnt     <= 16'd0;
                    end
                end
                S_WAIT_BUSY_LOW: begin
                    r_trigger <= 1'b0;
                    if (!r_busy_sync) begin
                        r_state <= S_DEAD;
                        r_cnt   <= 16'd0;
                    end
                end
                S_SHIFT: begin
                    // The shifter is zero-filled, so edges past bit 31 drive 0.
                    if (!r_busy_sync) begin
                        r_state   <= S_DEAD;
                        r_trigger <= 1'b0;
                        r_cnt     <= 16'd0;
                    end else if (w_tclk_rise) begin
                        r_trigger <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                end
                S_DEAD: begin
                    r_trigger <= 1'b0;
                    r_cnt     <= r_cnt + 16'd1;
                    if (r_cnt == 16'(DEAD_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_trigger <= 1'b0;
                end
            endcase
        end
    end

    assign o_tlu_trigger    = r_trigger;
    assign o_trigger_number = r_number;
    assign o_timeout_error  = r_timeout_error;
    assign o_skipped_count  = r_skipped;
    assign o_idle_flag      = (r_state == S_IDLE);

endmodule
